// File: rtl/plru8_victim_sel.sv
// Tree pseudo-LRU victim selector for an 8-way set-associative cache.
// Holds 7 PLRU bits and 8 valid bits per set and returns a victim way over a valid/ready handshake.
module plru8_victim_sel #(
  parameter int NUM_SETS = 64,
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             busy_o,
  input  logic             hit_valid_i,
  input  logic [IDX_W-1:0] hit_index_i,
  input  logic [2:0]       hit_way_i,
  input  logic             alloc_req_i,
  input  logic [IDX_W-1:0] alloc_index_i,
  output logic             alloc_ready_o,
  output logic             victim_valid_o,
  output logic [2:0]       victim_way_o,
  input  logic             victim_ready_i,
  input  logic             inv_valid_i,
  input  logic [IDX_W-1:0] inv_index_i,
  input  logic [2:0]       inv_way_i
);

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       way_q;

  logic [6:0] plru [NUM_SETS];
  logic [7:0] vld  [NUM_SETS];

  logic       accept;
  logic       fill_en;
  logic [6:0] fill_base;
  logic [7:0] fill_vld;

  // Point the three tree nodes on the path to w away from w.
  function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
    logic [6:0] r;
    logic [2:0] i1;
    logic [2:0] i2;
    r     = b;
    i1    = 3'd1 + {2'b00, w[2]};
    i2    = 3'd3 + {1'b0, w[2], 1'b0} + {2'b00, w[1]};
    r[0]  = ~w[2];
    r[i1] = ~w[1];
    r[i2] = ~w[0];
    return r;
  endfunction

  // Lowest invalid way first; otherwise follow the tree bits to the LRU leaf.
  function automatic logic [2:0] sel_victim(input logic [6:0] b, input logic [7:0] v);
    logic [2:0] w;
    logic [2:0] i1;
    logic [2:0] i2;
    logic       found;
    found = 1'b0;
    w     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) begin
        w     = 3'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      w[2] = b[0];
      i1   = 3'd1 + {2'b00, w[2]};
      w[1] = b[i1];
      i2   = 3'd3 + {1'b0, w[2], 1'b0} + {2'b00, w[1]};
      w[0] = b[i2];
    end
    return w;
  endfunction

  assign busy_o         = (state == INIT);
  assign alloc_ready_o  = (state == IDLE);
  assign victim_valid_o = (state == RESP);
  assign victim_way_o   = way_q;
  assign accept         = (state == IDLE) && alloc_req_i;
  assign fill_en        = (state == RESP) && victim_ready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (ptr == LAST_SET) state_nxt = IDLE;
      IDLE:    if (alloc_req_i)     state_nxt = RESP;
      RESP:    if (victim_ready_i)  state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Same-set ordering: hit touch before fill touch, fill valid-set before invalidate clear.
  always_comb begin
    fill_base = plru[idx_q];
    if (hit_valid_i && (hit_index_i == idx_q))
      fill_base = plru_touch(plru[idx_q], hit_way_i);
    fill_vld = vld[idx_q] | (8'd1 << way_q);
    if (inv_valid_i && (inv_index_i == idx_q))
      fill_vld = fill_vld & ~(8'd1 << inv_way_i);
  end

  // Control stage: FSM, sweep pointer and the held victim
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= INIT;
      ptr   <= '0;
      idx_q <= '0;
      way_q <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == INIT)
        ptr <= ptr + 1'b1;
      if (accept) begin
        idx_q <= alloc_index_i;
        way_q <= sel_victim(plru[alloc_index_i], vld[alloc_index_i]);
      end
    end
  end

  // State arrays: later writes to the same set override earlier ones
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      plru[ptr] <= 7'd0;
      vld[ptr]  <= 8'd0;
    end else begin
      if (hit_valid_i)
        plru[hit_index_i] <= plru_touch(plru[hit_index_i], hit_way_i);
      if (fill_en)
        plru[idx_q] <= plru_touch(fill_base, way_q);
      if (inv_valid_i)
        vld[inv_index_i] <= vld[inv_index_i] & ~(8'd1 << inv_way_i);
      if (fill_en)
        vld[idx_q] <= fill_vld;
    end
  end

endmodule

// File: tb/tb_plru8_victim_sel.sv
// Directed bench for plru8_victim_sel: expected victims are queued at issue time
// and a negedge monitor checks each committed victim against the queue.
module tb_plru8_victim_sel;

  localparam int NUM_SETS = 64;
  localparam int IDX_W    = 6;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             busy_o;
  logic             hit_valid_i;
  logic [IDX_W-1:0] hit_index_i;
  logic [2:0]       hit_way_i;
  logic             alloc_req_i;
  logic [IDX_W-1:0] alloc_index_i;
  logic             alloc_ready_o;
  logic             victim_valid_o;
  logic [2:0]       victim_way_o;
  logic             victim_ready_i;
  logic             inv_valid_i;
  logic [IDX_W-1:0] inv_index_i;
  logic [2:0]       inv_way_i;

  int n_total = 0;
  int n_pass  = 0;
  logic [2:0] sb[$];

  plru8_victim_sel #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .busy_o(busy_o),
    .hit_valid_i(hit_valid_i), .hit_index_i(hit_index_i), .hit_way_i(hit_way_i),
    .alloc_req_i(alloc_req_i), .alloc_index_i(alloc_index_i), .alloc_ready_o(alloc_ready_o),
    .victim_valid_o(victim_valid_o), .victim_way_o(victim_way_o), .victim_ready_i(victim_ready_i),
    .inv_valid_i(inv_valid_i), .inv_index_i(inv_index_i), .inv_way_i(inv_way_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every committed victim must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (!rst_i && victim_valid_o && victim_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_victim", 1, 0);
      end else begin
        check("victim_way", int'(victim_way_o), int'(sb.pop_front()));
      end
    end
  end

  task automatic wait_init();
    int cnt;
    cnt = 0;
    while (busy_o && cnt < 200) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    check("init_cycles", cnt, NUM_SETS);
    check("ready_after_init", int'(alloc_ready_o), 1);
  endtask

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (!alloc_ready_o && cnt < 200) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    if (cnt >= 200) check("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [IDX_W-1:0] idx, input logic [2:0] exp);
    wait_ready();
    alloc_req_i   = 1'b1;
    alloc_index_i = idx;
    sb.push_back(exp);
    @(posedge clk_i); #1;
    alloc_req_i = 1'b0;
  endtask

  task automatic commit();
    victim_ready_i = 1'b1;
    @(posedge clk_i); #1;
    victim_ready_i = 1'b0;
    hit_valid_i    = 1'b0;
    inv_valid_i    = 1'b0;
  endtask

  task automatic alloc_commit(input logic [IDX_W-1:0] idx, input logic [2:0] exp);
    issue(idx, exp);
    commit();
  endtask

  initial begin
    logic [2:0] seq3 [8];
    seq3 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    rst_i = 1'b1;
    hit_valid_i = 1'b0; hit_index_i = '0; hit_way_i = 3'd0;
    alloc_req_i = 1'b0; alloc_index_i = '0;
    victim_ready_i = 1'b0;
    inv_valid_i = 1'b0; inv_index_i = '0; inv_way_i = 3'd0;

    // Reset values and init sweep length
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", int'(busy_o), 1);
    check("rst_alloc_ready", int'(alloc_ready_o), 0);
    check("rst_victim_valid", int'(victim_valid_o), 0);
    check("rst_victim_way", int'(victim_way_o), 0);
    rst_i = 1'b0;
    wait_init();

    // Empty set fills invalid ways in ascending order
    for (int i = 0; i < 8; i++) alloc_commit(6'd5, 3'(i));

    // Full set with all-zero tree walks the whole PLRU cycle
    for (int i = 0; i < 8; i++) alloc_commit(6'd5, seq3[i]);

    // Another set is untouched by set 5 activity
    alloc_commit(6'd6, 3'd0);

    // Hit way 4 steers the victim away from it
    hit_valid_i = 1'b1; hit_index_i = 6'd5; hit_way_i = 3'd4;
    @(posedge clk_i); #1;
    hit_valid_i = 1'b0;
    issue(6'd5, 3'd0);
    // Hit way 7 in the commit cycle of way 0: fill touch wins on the root bit
    hit_valid_i = 1'b1; hit_index_i = 6'd5; hit_way_i = 3'd7;
    commit();
    alloc_commit(6'd5, 3'd5);

    // Invalidated way is picked next; invalidate on the fill edge wins
    inv_valid_i = 1'b1; inv_index_i = 6'd5; inv_way_i = 3'd3;
    @(posedge clk_i); #1;
    inv_valid_i = 1'b0;
    issue(6'd5, 3'd3);
    inv_valid_i = 1'b1; inv_index_i = 6'd5; inv_way_i = 3'd3;
    commit();
    alloc_commit(6'd5, 3'd3);
    alloc_commit(6'd5, 3'd6);

    // Held victim stays stable under hits, then reset aborts the response
    issue(6'd5, 3'd1);
    for (int i = 0; i < 10; i++) begin
      hit_valid_i = 1'b1; hit_index_i = 6'd5; hit_way_i = 3'(i);
      @(posedge clk_i); #1;
      check("hold_valid", int'(victim_valid_o), 1);
      check("hold_way", int'(victim_way_o), 1);
      check("hold_alloc_ready", int'(alloc_ready_o), 0);
    end
    hit_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("abort_victim_valid", int'(victim_valid_o), 0);
    check("abort_busy", int'(busy_o), 1);
    sb.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    wait_init();
    alloc_commit(6'd5, 3'd0);

    repeat (2) @(posedge clk_i);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
